// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network inference sequencer: FSM encoding,
// default widths and boolean constants.
package nn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2
    } nnState_t;

    localparam int DEFAULT_ADDR_WIDTH  = 10;
    localparam int DEFAULT_CLASS_WIDTH = 4;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

endpackage

// File: rtl/nn_result_fifo.sv
// Small circular FIFO holding finished predictions; a pop and a push in the
// same cycle are both honoured, even when the FIFO is full.
module nn_result_fifo
    import nn_pkg::*;
#(
    parameter int WIDTH = DEFAULT_CLASS_WIDTH,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_WIDTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int COUNT_WIDTH = $clog2(DEPTH + 1);
    localparam logic [PTR_WIDTH-1:0] LAST_PTR = PTR_WIDTH'(DEPTH - 1);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [PTR_WIDTH-1:0] wrPtr;
    logic [PTR_WIDTH-1:0] rdPtr;
    logic                 pushEff;
    logic                 popEff;

    function automatic logic [PTR_WIDTH-1:0] nextPtr(input logic [PTR_WIDTH-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + PTR_WIDTH'(1);
    endfunction

    // Status flags and effective push/pop qualification
    always_comb begin
        empty   = (count == '0);
        full    = (count == COUNT_WIDTH'(DEPTH));
        popEff  = pop & ~empty;
        pushEff = push & (~full | popEff);
        dout    = mem[rdPtr];
    end

    // Storage write
    always_ff @(posedge clk) begin
        if (pushEff) begin
            mem[wrPtr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (pushEff) wrPtr <= nextPtr(wrPtr);
            if (popEff)  rdPtr <= nextPtr(rdPtr);
            case ({pushEff, popEff})
                2'b10:   count <= count + COUNT_WIDTH'(1);
                2'b01:   count <= count - COUNT_WIDTH'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/nn_layer_sequencer.sv
// Chains NUM_LAYERS layer blocks through a start/done handshake, routes
// weight/bias writes to one layer while idle, and buffers predictions.
module nn_layer_sequencer
    import nn_pkg::*;
#(
    parameter int NUM_LAYERS     = 2,
    parameter int SEL_WIDTH      = 2,
    parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH     = 64,
    parameter int CLASS_WIDTH    = DEFAULT_CLASS_WIDTH,
    parameter int RESULT_DEPTH   = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   masterClk,
    input  logic                   reset,
    input  logic                   inputsInbound,
    output logic                   readyForInputs,
    input  logic                   weightWriteEnable,
    input  logic                   biasWriteEnable,
    input  logic [SEL_WIDTH-1:0]   layerWriteSelect,
    input  logic [ADDR_WIDTH-1:0]  writeAddressSelect,
    input  logic [DATA_WIDTH-1:0]  writeIn,
    output logic [NUM_LAYERS-1:0]  layerWeightWE,
    output logic [NUM_LAYERS-1:0]  layerBiasWE,
    output logic [ADDR_WIDTH-1:0]  layerWriteAddr,
    output logic [DATA_WIDTH-1:0]  layerWriteData,
    output logic                   writeRejected,
    output logic [NUM_LAYERS-1:0]  layerStart,
    input  logic [NUM_LAYERS-1:0]  layerDone,
    input  logic [CLASS_WIDTH-1:0] finalClass,
    output logic                   predictionReady,
    output logic [CLASS_WIDTH-1:0] predictionOut,
    input  logic                   predictionRecieved,
    output logic                   busy,
    output logic                   timeoutError
);

    localparam int IDX_WIDTH   = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam int WD_WIDTH    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int COUNT_WIDTH = $clog2(RESULT_DEPTH + 1);
    localparam logic [IDX_WIDTH-1:0]   LAST_INDEX   = IDX_WIDTH'(NUM_LAYERS - 1);
    localparam logic [WD_WIDTH-1:0]    WD_LAST      = WD_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [SEL_WIDTH:0]     SELECT_LIMIT = (SEL_WIDTH + 1)'(NUM_LAYERS);

    nnState_t               state;
    logic [IDX_WIDTH-1:0]   layerIndex;
    logic [WD_WIDTH-1:0]    wdCount;
    logic                   anyWrite;
    logic                   writeAccepted;
    logic                   currentDone;
    logic                   watchdogExpired;
    logic [NUM_LAYERS-1:0]  writeOnehot;
    logic                   fifoPush;
    logic                   fifoEmpty;
    logic                   fifoFull;
    logic [COUNT_WIDTH-1:0] fifoCount;
    logic [CLASS_WIDTH-1:0] fifoHead;

    // Handshake decode, write qualification and visible status
    always_comb begin
        anyWrite        = weightWriteEnable | biasWriteEnable;
        writeAccepted   = (state == IDLE) && ({1'b0, layerWriteSelect} < SELECT_LIMIT);
        writeOnehot     = NUM_LAYERS'(1'b1) << layerWriteSelect;
        currentDone     = layerDone[layerIndex];
        watchdogExpired = (TIMEOUT_CYCLES != 0) && (wdCount == WD_LAST);
        fifoPush        = (state == RUN) && currentDone && (layerIndex == LAST_INDEX);
        readyForInputs  = (state == IDLE) && !fifoFull && !anyWrite;
        busy            = (state != IDLE);
        predictionReady = (fifoCount != '0);
        predictionOut   = fifoEmpty ? '0 : fifoHead;
    end

    // Inference FSM with layer index, watchdog and start pulses
    always_ff @(posedge masterClk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            layerIndex   <= '0;
            wdCount      <= '0;
            layerStart   <= '0;
            timeoutError <= FALSE;
        end else begin
            layerStart <= '0;
            case (state)
                IDLE: begin
                    if (inputsInbound && readyForInputs) begin
                        state      <= START;
                        layerIndex <= '0;
                        layerStart <= NUM_LAYERS'(1'b1);
                    end
                end
                START: begin
                    wdCount <= '0;
                    state   <= RUN;
                end
                RUN: begin
                    if (currentDone) begin
                        if (layerIndex == LAST_INDEX) begin
                            state <= IDLE;
                        end else begin
                            layerIndex <= layerIndex + IDX_WIDTH'(1);
                            layerStart <= NUM_LAYERS'(1'b1) << (layerIndex + IDX_WIDTH'(1));
                            state      <= START;
                        end
                    end else if (watchdogExpired) begin
                        timeoutError <= TRUE;
                        state        <= IDLE;
                    end else begin
                        wdCount <= wdCount + WD_WIDTH'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Parameter-write register; address/data only move on an accepted write
    always_ff @(posedge masterClk or posedge reset) begin
        if (reset) begin
            layerWeightWE  <= '0;
            layerBiasWE    <= '0;
            layerWriteAddr <= '0;
            layerWriteData <= '0;
            writeRejected  <= FALSE;
        end else begin
            layerWeightWE <= (weightWriteEnable && writeAccepted) ? writeOnehot : '0;
            layerBiasWE   <= (biasWriteEnable && writeAccepted) ? writeOnehot : '0;
            writeRejected <= anyWrite && !writeAccepted;
            if (anyWrite && writeAccepted) begin
                layerWriteAddr <= writeAddressSelect;
                layerWriteData <= writeIn;
            end
        end
    end

    nn_result_fifo #(
        .WIDTH (CLASS_WIDTH),
        .DEPTH (RESULT_DEPTH)
    ) resultFifo (
        .clk   (masterClk),
        .reset (reset),
        .push  (fifoPush),
        .pop   (predictionRecieved),
        .din   (finalClass),
        .dout  (fifoHead),
        .empty (fifoEmpty),
        .full  (fifoFull),
        .count (fifoCount)
    );

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Directed bench for nn_layer_sequencer: 3 layers, 2-entry result FIFO,
// 16-cycle watchdog; predictions checked against a scoreboard queue.
module tb_nn_layer_sequencer;

    localparam int NL = 3;
    localparam int SW = 2;
    localparam int AW = 10;
    localparam int DW = 64;
    localparam int CW = 4;
    localparam int RD = 2;
    localparam int TO = 16;

    logic          masterClk = 1'b0;
    logic          reset = 1'b1;
    logic          inputsInbound = 1'b0;
    logic          readyForInputs;
    logic          weightWriteEnable = 1'b0;
    logic          biasWriteEnable = 1'b0;
    logic [SW-1:0] layerWriteSelect = '0;
    logic [AW-1:0] writeAddressSelect = '0;
    logic [DW-1:0] writeIn = '0;
    logic [NL-1:0] layerWeightWE;
    logic [NL-1:0] layerBiasWE;
    logic [AW-1:0] layerWriteAddr;
    logic [DW-1:0] layerWriteData;
    logic          writeRejected;
    logic [NL-1:0] layerStart;
    logic [NL-1:0] layerDone = '0;
    logic [CW-1:0] finalClass = '0;
    logic          predictionReady;
    logic [CW-1:0] predictionOut;
    logic          predictionRecieved = 1'b0;
    logic          busy;
    logic          timeoutError;

    int passCount = 0;
    int totalCount = 0;
    logic [CW-1:0] sbQ [$];

    always #5 masterClk = ~masterClk;

    nn_layer_sequencer #(
        .NUM_LAYERS(NL), .SEL_WIDTH(SW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .CLASS_WIDTH(CW), .RESULT_DEPTH(RD), .TIMEOUT_CYCLES(TO)
    ) dut (
        .masterClk(masterClk), .reset(reset),
        .inputsInbound(inputsInbound), .readyForInputs(readyForInputs),
        .weightWriteEnable(weightWriteEnable), .biasWriteEnable(biasWriteEnable),
        .layerWriteSelect(layerWriteSelect), .writeAddressSelect(writeAddressSelect),
        .writeIn(writeIn), .layerWeightWE(layerWeightWE), .layerBiasWE(layerBiasWE),
        .layerWriteAddr(layerWriteAddr), .layerWriteData(layerWriteData),
        .writeRejected(writeRejected), .layerStart(layerStart), .layerDone(layerDone),
        .finalClass(finalClass), .predictionReady(predictionReady),
        .predictionOut(predictionOut), .predictionRecieved(predictionRecieved),
        .busy(busy), .timeoutError(timeoutError)
    );

    task automatic tick();
        @(negedge masterClk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        totalCount++;
        assert (obs === exp) passCount++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic waitStart(input int k);
        logic [NL-1:0] expStart;
        int i;
        expStart = NL'(1) << k;
        i = 0;
        while (layerStart == '0 && i < 20) begin
            tick();
            i++;
        end
        check($sformatf("layerStart%0d", k), layerStart, expStart);
    endtask

    task automatic doLayer(input int k, input bit popAtDone);
        logic [CW-1:0] expHead;
        waitStart(k);
        tick();
        check("startOneCycle", layerStart, 0);
        repeat (3) tick();
        if (popAtDone) begin
            expHead = (sbQ.size() > 0) ? sbQ.pop_front() : '0;
            check("headBeforeSwap", predictionOut, expHead);
            predictionRecieved = 1'b1;
        end
        layerDone[k] = 1'b1;
        tick();
        layerDone = '0;
        predictionRecieved = 1'b0;
    endtask

    task automatic startInference(input logic [CW-1:0] cls, input bit expectResult);
        check("readyBeforeStart", readyForInputs, 1);
        finalClass = cls;
        inputsInbound = 1'b1;
        if (expectResult) sbQ.push_back(cls);
        tick();
        inputsInbound = 1'b0;
        check("busyAfterStart", busy, 1);
    endtask

    task automatic runInference(input logic [CW-1:0] cls);
        startInference(cls, 1'b1);
        for (int k = 0; k < NL; k++) doLayer(k, 1'b0);
        check("readyAfterLast", predictionReady, 1);
        check("idleAfterLast", busy, 0);
    endtask

    task automatic popCheck();
        logic [CW-1:0] expHead;
        check("popReady", predictionReady, 1);
        expHead = (sbQ.size() > 0) ? sbQ.pop_front() : '0;
        check("popHead", predictionOut, expHead);
        predictionRecieved = 1'b1;
        tick();
        predictionRecieved = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL globalTimeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (2) tick();
        check("rstWeightWE", layerWeightWE, 0);
        check("rstBiasWE", layerBiasWE, 0);
        check("rstRejected", writeRejected, 0);
        check("rstStart", layerStart, 0);
        check("rstPredReady", predictionReady, 0);
        check("rstPredOut", predictionOut, 0);
        check("rstBusy", busy, 0);
        check("rstTimeout", timeoutError, 0);
        check("rstReady", readyForInputs, 1);
        reset = 1'b0;
        tick();

        // Basic inference
        runInference(4'd7);
        check("basicPredOut", predictionOut, 7);
        check("basicReady", readyForInputs, 1);
        popCheck();
        check("basicEmptyReady", predictionReady, 0);
        check("basicEmptyOut", predictionOut, 0);

        // Weight write routing
        weightWriteEnable = 1'b1;
        layerWriteSelect = 2'd1;
        writeAddressSelect = 10'h2A5;
        writeIn = 64'hDEAD;
        #1;
        check("readyDuringWrite", readyForInputs, 0);
        tick();
        weightWriteEnable = 1'b0;
        check("wrWeightWE", layerWeightWE, 3'b010);
        check("wrBiasWE", layerBiasWE, 0);
        check("wrAddr", layerWriteAddr, 10'h2A5);
        check("wrData", layerWriteData, 64'hDEAD);
        check("wrNotRejected", writeRejected, 0);
        tick();
        check("wrWeightWEclr", layerWeightWE, 0);
        check("wrAddrHold", layerWriteAddr, 10'h2A5);

        // Both strobes
        weightWriteEnable = 1'b1;
        biasWriteEnable = 1'b1;
        layerWriteSelect = 2'd2;
        writeAddressSelect = 10'h0F0;
        writeIn = 64'h1234;
        tick();
        weightWriteEnable = 1'b0;
        biasWriteEnable = 1'b0;
        check("bothWeightWE", layerWeightWE, 3'b100);
        check("bothBiasWE", layerBiasWE, 3'b100);

        // Out-of-range select
        biasWriteEnable = 1'b1;
        layerWriteSelect = 2'd3;
        writeAddressSelect = 10'h111;
        writeIn = 64'h5555;
        tick();
        biasWriteEnable = 1'b0;
        check("selRejected", writeRejected, 1);
        check("selBiasWE", layerBiasWE, 0);
        check("selWeightWE", layerWeightWE, 0);
        check("selAddrHold", layerWriteAddr, 10'h0F0);
        tick();
        check("selRejectedPulse", writeRejected, 0);

        // Start/write collision: write wins
        inputsInbound = 1'b1;
        weightWriteEnable = 1'b1;
        layerWriteSelect = 2'd0;
        writeAddressSelect = 10'h003;
        writeIn = 64'h77;
        tick();
        inputsInbound = 1'b0;
        weightWriteEnable = 1'b0;
        check("collWeightWE", layerWeightWE, 3'b001);
        check("collNoStart", layerStart, 0);
        check("collNotBusy", busy, 0);
        tick();
        check("collStillIdle", busy, 0);

        // Write while busy
        startInference(4'd3, 1'b1);
        doLayer(0, 1'b0);
        waitStart(1);
        tick();
        biasWriteEnable = 1'b1;
        layerWriteSelect = 2'd0;
        tick();
        biasWriteEnable = 1'b0;
        check("busyRejected", writeRejected, 1);
        check("busyBiasWE", layerBiasWE, 0);
        check("busyWeightWE", layerWeightWE, 0);
        repeat (2) tick();
        layerDone[1] = 1'b1;
        tick();
        layerDone = '0;
        doLayer(2, 1'b0);

        // FIFO full
        runInference(4'd10);
        check("fullNotReady", readyForInputs, 0);
        inputsInbound = 1'b1;
        tick();
        inputsInbound = 1'b0;
        check("fullNoStart", layerStart, 0);
        check("fullNotBusy", busy, 0);
        popCheck();
        check("popReadyAgain", readyForInputs, 1);

        // Concurrent push and pop
        startInference(4'd5, 1'b1);
        doLayer(0, 1'b0);
        doLayer(1, 1'b0);
        doLayer(2, 1'b1);
        check("swapReady", predictionReady, 1);
        check("swapHead", predictionOut, 5);
        check("swapNotFull", readyForInputs, 1);
        popCheck();
        check("swapDrained", predictionReady, 0);

        // Watchdog on layer 1
        runInference(4'd9);
        startInference(4'd12, 1'b0);
        doLayer(0, 1'b0);
        waitStart(1);
        repeat (16) tick();
        check("wdNotYet", timeoutError, 0);
        check("wdStillBusy", busy, 1);
        tick();
        check("wdFired", timeoutError, 1);
        check("wdIdle", busy, 0);
        check("wdFifoReady", predictionReady, 1);
        check("wdFifoHead", predictionOut, 9);
        repeat (3) tick();
        check("wdSticky", timeoutError, 1);
        popCheck();
        check("wdFifoOne", predictionReady, 0);

        // Reset mid-run with one stored prediction
        runInference(4'd6);
        startInference(4'd2, 1'b0);
        doLayer(0, 1'b0);
        waitStart(1);
        repeat (2) tick();
        reset = 1'b1;
        #1;
        check("midRstBusy", busy, 0);
        check("midRstPredReady", predictionReady, 0);
        check("midRstPredOut", predictionOut, 0);
        check("midRstStart", layerStart, 0);
        check("midRstTimeout", timeoutError, 0);
        sbQ.delete();
        tick();
        reset = 1'b0;
        tick();
        check("postRstReady", readyForInputs, 1);
        check("postRstPredReady", predictionReady, 0);
        runInference(4'd4);
        popCheck();

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule

// File: doc/nn_layer_sequencer.md
# nn_layer_sequencer

Parametrised top-level inference sequencer and parameter-write router for the neural network, replacing the fixed two-layer controller. It chains NUM_LAYERS layer blocks with a start/done handshake and routes weight/bias writes to one selected layer. Writes are locked out while an inference is running. Predictions are buffered in a small result FIFO, and a per-layer watchdog flags a layer that never finishes.

## Interface
Parameters:
- NUM_LAYERS, 2 — layer blocks chained in order; layer 0 is the input layer. Must be ≥1.
- SEL_WIDTH, 2 — width of layerWriteSelect. Must satisfy 2^SEL_WIDTH ≥ NUM_LAYERS.
- ADDR_WIDTH, 10 — write address width.
- DATA_WIDTH, 64 — write data width.
- CLASS_WIDTH, 4 — prediction class width.
- RESULT_DEPTH, 2 — result FIFO entries. Must be ≥1.
- TIMEOUT_CYCLES, 4096 — watchdog limit per layer; 0 disables the watchdog.

Ports:
- masterClk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- inputsInbound  in  1  request to start an inference
- readyForInputs  out  1  start request will be accepted this cycle
- weightWriteEnable  in  1  weight write strobe
- biasWriteEnable  in  1  bias write strobe
- layerWriteSelect  in  SEL_WIDTH  target layer
- writeAddressSelect  in  ADDR_WIDTH  write address
- writeIn  in  DATA_WIDTH  write data
- layerWeightWE  out  NUM_LAYERS  one-hot weight enable, registered
- layerBiasWE  out  NUM_LAYERS  one-hot bias enable, registered
- layerWriteAddr  out  ADDR_WIDTH  registered address
- layerWriteData  out  DATA_WIDTH  registered data
- writeRejected  out  1  one-cycle pulse: write dropped
- layerStart  out  NUM_LAYERS  one-cycle start pulse per layer
- layerDone  in  NUM_LAYERS  layer finished (level or pulse)
- finalClass  in  CLASS_WIDTH  last layer's class; valid with layerDone[NUM_LAYERS-1]
- predictionReady  out  1  FIFO non-empty
- predictionOut  out  CLASS_WIDTH  FIFO head; 0 when empty
- predictionRecieved  in  1  pop FIFO head
- busy  out  1  inference in progress
- timeoutError  out  1  sticky watchdog flag

## Operation
States: IDLE, START, RUN.

- **Reset.** All registered outputs are 0, the FIFO is empty, layer index is 0, timeoutError is 0. readyForInputs is therefore 1 directly out of reset.
- **readyForInputs.** Combinational: (IDLE) & !fifoFull & !weightWriteEnable & !biasWriteEnable.
- **IDLE.**
  - If inputsInbound & readyForInputs: go to START with index 0.
  - A write in the same cycle as inputsInbound wins; the start is ignored because readyForInputs is 0.
- **START.**
  - layerStart[index] = 1 for exactly one cycle.
  - Clear the watchdog count, then go to RUN.
- **RUN.** Wait for layerDone[index]; done bits of other layers are ignored.
  - Done received, index < NUM_LAYERS-1: index+1, go to START.
  - Done received on the last layer: push finalClass into the FIFO, go to IDLE.
  - Watchdog count reaches TIMEOUT_CYCLES with no done: set timeoutError, push nothing, go to IDLE.
- **busy.** busy = (state ≠ IDLE).
- **Write routing.**
  - In IDLE with layerWriteSelect < NUM_LAYERS: one cycle later, bit [select] of layerWeightWE / layerBiasWE mirrors the strobes. Address and data are registered alongside.
  - Both strobes high: both enables asserted.
  - Write while busy, or with select ≥ NUM_LAYERS: no enable, writeRejected pulses the next cycle.
  - When no write is issued, the enables are 0 and address/data hold their last value.
- **FIFO.**
  - Pop on predictionRecieved & !empty.
  - Push and pop in the same cycle are both performed, including when full.
  - Pop when empty is ignored.
  - Pointers wrap modulo RESULT_DEPTH.
  - A push cannot occur while full, because a start is only accepted when not full.
- **timeoutError.** Cleared only by reset.
- **Reset mid-operation.** Reset during RUN aborts the inference, flushes the FIFO and returns to IDLE asynchronously.

## Timing
- inputsInbound accepted at edge N → layerStart[0] high in cycle N+1 → RUN from N+2.
- layerDone[k] sampled at edge M → layerStart[k+1] high in cycle M+1.
- Last done at edge M → predictionReady high and predictionOut valid in cycle M+1. readyForInputs returns in cycle M+1 if the FIFO is not full.
- Write and writeRejected latency: 1 cycle.
- Minimum inference: 2·NUM_LAYERS cycles plus the layers' own latency.
- Watchdog fires on RUN cycle TIMEOUT_CYCLES of the current layer. timeoutError is visible the next cycle.

## Structure
- **Shared package nn_pkg.**
  - State encoding: IDLE=0, START=1, RUN=2.
  - Default widths: ADDR 10, CLASS 4.
  - TRUE/FALSE constants.
- **Sub-module nn_result_fifo.**
  - Parameters: width CLASS_WIDTH, depth RESULT_DEPTH.
  - Ports: push, pop, din, dout, empty, full, count.
  - Same asynchronous reset.
- **Top-level logic.** The FSM, layer index counter, watchdog counter and write register stay in the top level.

## Test plan
- **Basic inference.** NUM_LAYERS=3. Start; layerDone[0..2] returned 5 cycles after each start; finalClass=7 → start pulses on 0,1,2 in order; predictionOut=7; predictionReady high one cycle after the last done; pop clears it.
- **Write routing.**
  - Weight write to select 1, address 0x2A5, data 0xDEAD → layerWeightWE=3'b010 one cycle later with matching address/data.
  - Select 3 with NUM_LAYERS=3 → writeRejected pulse, no enable.
- **Write while busy and start/write collision.**
  - Bias write during RUN → writeRejected, enables stay 0.
  - Write coincident with inputsInbound in IDLE → write issued, no layerStart.
- **FIFO full and concurrent push/pop.**
  - RESULT_DEPTH=2: two inferences with no pops → readyForInputs 0; pop → readyForInputs 1.
  - Push and pop in the same cycle → count unchanged, order preserved.
- **Watchdog.** TIMEOUT_CYCLES=16; layer 1 never finishes → timeoutError set after 16 RUN cycles, FSM in IDLE, FIFO unchanged, flag stays set.
- **Reset mid-run.** Assert reset during RUN of layer 1 with one FIFO entry → all outputs 0 immediately, predictionReady 0, readyForInputs 1 after release.
